// File: rtl/pos_data_preprocessor_mp_pkg.sv
// Shared types for the multi-phase position preprocessor: particle IDs,
// position tuples, the preprocessor FSM state and the count-field helper.
package md_pkg;
    localparam int ID_WIDTH        = 8;
    localparam int OFFSET_WIDTH    = 16;
    localparam int NUM_FILTER      = 7;
    localparam int NUM_PHASES      = 2;
    // Bit offset of the particle-count field inside a count-cycle read word.
    localparam int PREPROC_CNT_LSB = 0;

    typedef logic [ID_WIDTH-1:0] particle_id_t;

    typedef struct packed {
        logic [OFFSET_WIDTH-1:0] z;
        logic [OFFSET_WIDTH-1:0] y;
        logic [OFFSET_WIDTH-1:0] x;
    } offset_tuple_t;

    typedef enum logic [2:0] {IDLE, COUNT, RUN, WAIT, DONE} preproc_state_t;

    // Particle count carried by a read word during the count cycle.
    function automatic particle_id_t cnt_field(input offset_tuple_t e);
        return e[PREPROC_CNT_LSB +: ID_WIDTH];
    endfunction
endpackage

// File: rtl/pos_data_preprocessor_mp_if.sv
// Bus between the cell-memory read side and the preprocessor. The slave
// modport is the preprocessor. PREPROC_PAIR_STATS_EN adds pair_count.
interface pos_data_preprocessor_mp_if
    import md_pkg::*;
#(
    parameter int NUM_FILTER = md_pkg::NUM_FILTER,
    parameter int NUM_PHASES = md_pkg::NUM_PHASES,
    parameter int PHASE_W    = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
);
    logic [PHASE_W-1:0]                           phase;
    logic                                         reading_particle_num;
    logic                                         pause_reading;
    offset_tuple_t [NUM_PHASES*NUM_FILTER-1:0]    rd_nb_position;
    particle_id_t                                 ref_id;
    particle_id_t                                 particle_id;
    offset_tuple_t [NUM_FILTER-1:0]               ref_pos;
    logic [NUM_FILTER-1:0]                        pair_valid;
    offset_tuple_t                                assembled_position;
    particle_id_t                                 prev_ref_id;
    particle_id_t                                 prev_particle_id;
    logic [PHASE_W-1:0]                           prev_phase;
    particle_id_t                                 ref_particle_count;
    logic                                         reading_done;
    logic                                         busy;
`ifdef PREPROC_PAIR_STATS_EN
    logic [NUM_FILTER-1:0][31:0]                  pair_count;
`endif

    modport master (
        output phase, reading_particle_num, pause_reading, rd_nb_position, ref_id, particle_id,
        input  ref_pos, pair_valid, assembled_position, prev_ref_id, prev_particle_id,
        input  prev_phase, ref_particle_count, reading_done, busy
`ifdef PREPROC_PAIR_STATS_EN
        , input pair_count
`endif
    );

    modport slave (
        input  phase, reading_particle_num, pause_reading, rd_nb_position, ref_id, particle_id,
        output ref_pos, pair_valid, assembled_position, prev_ref_id, prev_particle_id,
        output prev_phase, ref_particle_count, reading_done, busy
`ifdef PREPROC_PAIR_STATS_EN
        , output pair_count
`endif
    );
endinterface

// File: rtl/pos_data_preprocessor_mp_channel.sv
// One filter channel: particle count, reference-position latch, registered
// pair-valid and (with PREPROC_PAIR_STATS_EN) a saturating pair counter.
module pos_preproc_channel
    import md_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  offset_tuple_t entry_i,
    input  logic          cnt_load_i,
    input  logic          run_act_i,
    input  particle_id_t  ref_id_i,
    input  particle_id_t  particle_id_i,
    input  particle_id_t  prev_ref_id_i,
    input  particle_id_t  prev_particle_id_i,
    input  particle_id_t  home_cnt_i,
`ifdef PREPROC_PAIR_STATS_EN
    output logic [31:0]   pair_count_o,
`endif
    output offset_tuple_t ref_pos_o,
    output logic          pair_valid_o
);
    particle_id_t  cnt_q;
    offset_tuple_t ref_pos_q;
    logic          pv_q, pv_d, ref_hit;

    // The reference is only latched when it exists in this filter's cell.
    assign ref_hit = run_act_i && (ref_id_i != '0) && (particle_id_i == ref_id_i)
                     && (ref_id_i <= cnt_q);
    // Pairing of last cycle's address; ID 0 never forms a pair.
    assign pv_d    = run_act_i && (ref_id_i != '0) && (prev_ref_id_i != '0)
                     && (prev_particle_id_i != '0) && (prev_ref_id_i <= cnt_q)
                     && (prev_particle_id_i <= home_cnt_i);

    // Count capture happens even while paused.
    always_ff @(posedge clk) begin
        if (rst)             cnt_q <= '0;
        else if (cnt_load_i) cnt_q <= cnt_field(entry_i);
    end

    // Reference latch and pair-valid register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_pos_q <= '0;
            pv_q      <= 1'b0;
        end else begin
            if (ref_hit) ref_pos_q <= entry_i;
            pv_q <= pv_d;
        end
    end

`ifdef PREPROC_PAIR_STATS_EN
    logic [31:0] pair_cnt_q;
    // Saturating pulse counter, restarted by each new count capture.
    always_ff @(posedge clk) begin
        if (rst || cnt_load_i)              pair_cnt_q <= '0;
        else if (pv_q && (pair_cnt_q != '1)) pair_cnt_q <= pair_cnt_q + 32'd1;
    end
    assign pair_count_o = pair_cnt_q;
`endif

    assign ref_pos_o    = ref_pos_q;
    assign pair_valid_o = pv_q;
endmodule

// File: rtl/pos_data_preprocessor_mp.sv
// Multi-phase position preprocessor top: group mux, control FSM, home count
// and the one-cycle delayed inputs. PREPROC_PAIR_STATS_EN adds pair_count.
module pos_data_preprocessor_mp
    import md_pkg::*;
#(
    parameter int NUM_FILTER = md_pkg::NUM_FILTER,
    parameter int NUM_PHASES = md_pkg::NUM_PHASES,
    parameter int PHASE_W    = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input logic                       clk,
    input logic                       rst,
    pos_data_preprocessor_mp_if.slave bus
);
    preproc_state_t                 state_q, state_d;
    particle_id_t                   home_cnt_q, prev_ref_id_q, prev_particle_id_q;
    logic [PHASE_W-1:0]             prev_phase_q;
    offset_tuple_t                  asm_q;
    offset_tuple_t [NUM_FILTER-1:0] grp, ref_pos_w;
    logic [NUM_FILTER-1:0]          pv_w;
    logic                           run_act;

    // Route the current phase's group of cells to the filters.
    always_comb begin
        grp = '0;
        for (int g = 0; g < NUM_PHASES; g++)
            if (int'(bus.phase) == g)
                for (int i = 0; i < NUM_FILTER; i++)
                    grp[i] = bus.rd_nb_position[g*NUM_FILTER+i];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state; a count cycle overrides everything, a pause freezes the rest.
    always_comb begin
        state_d = state_q;
        if (bus.reading_particle_num) begin
            state_d = COUNT;
        end else if (!bus.pause_reading) begin
            case (state_q)
                COUNT: state_d = (home_cnt_q == '0) ? DONE : RUN;
                RUN: begin
                    if (bus.ref_id > home_cnt_q)           state_d = DONE;
                    else if (bus.particle_id > home_cnt_q) state_d = WAIT;
                end
                WAIT: begin
                    if (bus.ref_id > home_cnt_q)           state_d = DONE;
                    else if (bus.ref_id != prev_ref_id_q)  state_d = RUN;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Home count is only refreshed in phase 0 and survives the other phases.
    always_ff @(posedge clk) begin
        if (rst)
            home_cnt_q <= '0;
        else if (bus.reading_particle_num && (bus.phase == '0))
            home_cnt_q <= cnt_field(bus.rd_nb_position[0]);
    end

    // Delayed inputs and the broadcast home particle.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ref_id_q      <= '0;
            prev_particle_id_q <= '0;
            prev_phase_q       <= '0;
            asm_q              <= '0;
        end else begin
            prev_ref_id_q      <= bus.ref_id;
            prev_particle_id_q <= bus.particle_id;
            prev_phase_q       <= bus.phase;
            if (!bus.pause_reading) asm_q <= bus.rd_nb_position[0];
        end
    end

    assign run_act = (state_q == RUN) && !bus.pause_reading;

`ifdef PREPROC_PAIR_STATS_EN
    logic [NUM_FILTER-1:0][31:0] pc_w;
    assign bus.pair_count = pc_w;
`endif

    for (genvar i = 0; i < NUM_FILTER; i++) begin : g_ch
        pos_preproc_channel u_ch (
            .clk               (clk),
            .rst               (rst),
            .entry_i           (grp[i]),
            .cnt_load_i        (bus.reading_particle_num),
            .run_act_i         (run_act),
            .ref_id_i          (bus.ref_id),
            .particle_id_i     (bus.particle_id),
            .prev_ref_id_i     (prev_ref_id_q),
            .prev_particle_id_i(prev_particle_id_q),
            .home_cnt_i        (home_cnt_q),
`ifdef PREPROC_PAIR_STATS_EN
            .pair_count_o      (pc_w[i]),
`endif
            .ref_pos_o         (ref_pos_w[i]),
            .pair_valid_o      (pv_w[i])
        );
    end

    assign bus.ref_pos            = ref_pos_w;
    assign bus.pair_valid         = pv_w;
    assign bus.assembled_position = asm_q;
    assign bus.prev_ref_id        = prev_ref_id_q;
    assign bus.prev_particle_id   = prev_particle_id_q;
    assign bus.prev_phase         = prev_phase_q;
    assign bus.ref_particle_count = home_cnt_q;
    assign bus.reading_done       = (state_q == DONE);
    assign bus.busy               = (state_q != IDLE) && (state_q != DONE);
endmodule
